// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples
// the synchronised rows at the end of each column dwell, classifies each full
// sweep and debounces presses and releases over consecutive identical sweeps.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_e;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASING} state_e;

  // Hex value printed on the key at row r, column c.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b0000: key_lookup = 4'h1;  4'b0001: key_lookup = 4'h2;
      4'b0010: key_lookup = 4'h3;  4'b0011: key_lookup = 4'hA;
      4'b0100: key_lookup = 4'h4;  4'b0101: key_lookup = 4'h5;
      4'b0110: key_lookup = 4'h6;  4'b0111: key_lookup = 4'hB;
      4'b1000: key_lookup = 4'h7;  4'b1001: key_lookup = 4'h8;
      4'b1010: key_lookup = 4'h9;  4'b1011: key_lookup = 4'hC;
      4'b1100: key_lookup = 4'h0;  4'b1101: key_lookup = 4'hF;
      4'b1110: key_lookup = 4'hE;  default: key_lookup = 4'hD;
    endcase
  endfunction

  function automatic logic [2:0] count_low(input logic [3:0] lows);
    count_low = {2'b00, lows[0]} + {2'b00, lows[1]} + {2'b00, lows[2]} + {2'b00, lows[3]};
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [1:0] low_row(input logic [3:0] lows);
    if (lows[0])      low_row = 2'd0;
    else if (lows[1]) low_row = 2'd1;
    else if (lows[2]) low_row = 2'd2;
    else              low_row = 2'd3;
  endfunction

  logic [3:0]       row_meta_q, row_meta_d, row_sync_q, row_sync_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;     // 0, 1, or 2 meaning "two or more"
  logic [3:0]       acc_code_q, acc_code_d;
  res_e             res_kind_q, res_kind_d;
  logic [3:0]       res_code_q, res_code_d;
  logic             eval_q, eval_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] stable_q, stable_d, release_cnt_q, release_cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic             key_release_q, key_release_d;

  logic [3:0] lows;
  logic [2:0] n_low, tot;
  logic [1:0] base_cnt, sat_cnt;
  logic [3:0] base_code, sweep_code;

  // Two-flop synchroniser on the asynchronous row lines.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
  end

  // Column dwell, per-column row sampling and sweep accumulation.
  always_comb begin
    dwell_d    = dwell_q + 1'b1;
    col_idx_d  = col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    res_kind_d = res_kind_q;
    res_code_d = res_code_q;
    eval_d     = 1'b0;
    lows       = ~row_sync_q;
    n_low      = count_low(lows);
    base_cnt   = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
    base_code  = (col_idx_q == 2'd0) ? 4'h0 : acc_code_q;
    tot        = {1'b0, base_cnt} + n_low;
    sat_cnt    = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    sweep_code = (base_cnt == 2'd0 && n_low == 3'd1) ? key_lookup(low_row(lows), col_idx_q)
                                                     : base_code;
    if (dwell_q == DWELL_LAST) begin
      dwell_d    = '0;
      col_idx_d  = col_idx_q + 2'd1;
      acc_cnt_d  = sat_cnt;
      acc_code_d = sweep_code;
      if (col_idx_q == 2'd3) begin
        eval_d     = 1'b1;
        res_code_d = sweep_code;
        case (sat_cnt)
          2'd0:    res_kind_d = RES_NONE;
          2'd1:    res_kind_d = RES_SINGLE;
          default: res_kind_d = RES_MULTI;
        endcase
      end
    end
  end

  // Debounce state machine, acting once per completed sweep.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    stable_d      = stable_q;
    release_cnt_d = release_cnt_q;
    key_code_d    = key_code_q;
    key_held_d    = key_held_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (res_kind_q == RES_SINGLE) begin
            cand_d   = res_code_q;
            stable_d = CNT_W'(1);
            state_d  = CONFIRM;
          end
        end
        CONFIRM: begin
          if (res_kind_q == RES_SINGLE) begin
            if (res_code_q == cand_q) begin
              stable_d = stable_q + 1'b1;
            end else begin
              cand_d   = res_code_q;
              stable_d = CNT_W'(1);
            end
          end else begin
            stable_d = '0;
            state_d  = IDLE;
          end
        end
        HELD: begin
          if (res_kind_q == RES_NONE) begin
            release_cnt_d = CNT_W'(1);
            state_d       = RELEASING;
          end
        end
        default: begin
          if (res_kind_q == RES_NONE) begin
            release_cnt_d = release_cnt_q + 1'b1;
          end else begin
            release_cnt_d = '0;
            state_d       = HELD;
          end
        end
      endcase
      // Confirmation and release complete on the same sweep that reaches the target.
      if (state_d == CONFIRM && stable_d == DEB_TARGET) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        stable_d    = '0;
        state_d     = HELD;
      end else if (state_d == RELEASING && release_cnt_d == DEB_TARGET) begin
        key_release_d = 1'b1;
        key_held_d    = 1'b0;
        release_cnt_d = '0;
        state_d       = IDLE;
      end
    end
  end

  // Scan and synchroniser registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      dwell_q    <= '0;
      col_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'h0;
      res_kind_q <= RES_NONE;
      res_code_q <= 4'h0;
      eval_q     <= 1'b0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      res_kind_q <= res_kind_d;
      res_code_q <= res_code_d;
      eval_q     <= eval_d;
    end
  end

  // FSM state and registered key outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cand_q        <= 4'h0;
      stable_q      <= '0;
      release_cnt_q <= '0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      release_cnt_q <= release_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  // One-cold column drive decoded from the column index register.
  always_comb begin
    case (col_idx_q)
      2'd0:    col = 4'b1110;
      2'd1:    col = 4'b1101;
      2'd2:    col = 4'b1011;
      default: col = 4'b0111;
    endcase
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule
